// File: rtl/pulpino_clk_rst_pkg.sv
// Shared types and default constants for the PULPino board clock/reset front end.
package pulpino_clk_rst_pkg;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } rst_state_e;

    localparam int DEF_DIV_HALF        = 5;
    localparam int DEF_RST_HOLD_CYCLES = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_HB_HALF         = 25000000;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulpino_btn_debounce.sv
// Active-low push-button debouncer: 2-flop synchronizer followed by a stable-level counter.
module pulpino_btn_debounce
    import pulpino_clk_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_s;

    assign btn_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_n_i};
        level_d = level_q;
        cnt_d   = cnt_q;
        if (btn_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = btn_s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Released button is the idle level, so sync and level reset high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/pulpino_clk_rst_gen.sv
// Board clock/reset front end: clock divider, lock-gated core reset stretcher,
// debounced fetch enable and heartbeat LED.
module pulpino_clk_rst_gen
    import pulpino_clk_rst_pkg::*;
#(
    parameter int DIV_HALF        = DEF_DIV_HALF,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HB_HALF         = DEF_HB_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked_i,
    input  logic fetch_btn_n_i,
    output logic clk_div_o,
    output logic clk_div_rise_o,
    output logic core_rst_n_o,
    output logic fetch_enable_o,
    output logic heartbeat_o
);

    localparam int DIV_W = cnt_width(DIV_HALF);
    localparam int RST_W = cnt_width(RST_HOLD_CYCLES);
    localparam int HB_W  = cnt_width(HB_HALF);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             clk_div_q, clk_div_d;
    logic             rise_q, rise_d;
    logic [1:0]       lock_sync_q, lock_sync_d;
    rst_state_e       state_q, state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             fetch_en_q, fetch_en_d;
    logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
    logic             hb_q, hb_d;
    logic             locked_s;
    logic             btn_level;

    pulpino_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_n_i(fetch_btn_n_i),
        .level_o(btn_level)
    );

    assign locked_s = lock_sync_q[1];

    always_comb begin
        div_cnt_d    = div_cnt_q;
        clk_div_d    = clk_div_q;
        rise_d       = 1'b0;
        lock_sync_d  = {lock_sync_q[0], pll_locked_i};
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        core_rst_n_d = core_rst_n_q;
        hb_cnt_d     = hb_cnt_q;
        hb_d         = hb_q;

        // Divider free-runs independent of lock so the core clock is always alive.
        if (div_cnt_q == DIV_W'(DIV_HALF - 1)) begin
            div_cnt_d = '0;
            clk_div_d = ~clk_div_q;
            rise_d    = ~clk_div_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        case (state_q)
            HOLD: begin
                core_rst_n_d = 1'b0;
                if (!locked_s) begin
                    rst_cnt_d = '0;
                end else if (rise_q) begin
                    if (rst_cnt_q == RST_W'(RST_HOLD_CYCLES - 1)) begin
                        state_d      = RUN;
                        core_rst_n_d = 1'b1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RST_W'(1);
                    end
                end
            end
            RUN: begin
                core_rst_n_d = 1'b1;
                if (!locked_s) begin
                    state_d      = HOLD;
                    rst_cnt_d    = '0;
                    core_rst_n_d = 1'b0;
                end
            end
            default: begin
                state_d      = HOLD;
                rst_cnt_d    = '0;
                core_rst_n_d = 1'b0;
            end
        endcase

        fetch_en_d = (state_q == RUN) & ~btn_level;

        if (hb_cnt_q == HB_W'(HB_HALF - 1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q    <= '0;
            clk_div_q    <= 1'b0;
            rise_q       <= 1'b0;
            lock_sync_q  <= 2'b00;
            state_q      <= HOLD;
            rst_cnt_q    <= '0;
            core_rst_n_q <= 1'b0;
            fetch_en_q   <= 1'b0;
            hb_cnt_q     <= '0;
            hb_q         <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            clk_div_q    <= clk_div_d;
            rise_q       <= rise_d;
            lock_sync_q  <= lock_sync_d;
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            core_rst_n_q <= core_rst_n_d;
            fetch_en_q   <= fetch_en_d;
            hb_cnt_q     <= hb_cnt_d;
            hb_q         <= hb_d;
        end
    end

    assign clk_div_o      = clk_div_q;
    assign clk_div_rise_o = rise_q;
    assign core_rst_n_o   = core_rst_n_q;
    assign fetch_enable_o = fetch_en_q;
    assign heartbeat_o    = hb_q;

endmodule

// File: tb/tb_pulpino_clk_rst_gen.sv
// Bench for pulpino_clk_rst_gen with small parameters; expected outputs per clock edge
// are queued when stimulus is applied and compared after the edge.
module tb_pulpino_clk_rst_gen;

    localparam int SIG_DIV  = 0;
    localparam int SIG_RISE = 1;
    localparam int SIG_RSTN = 2;
    localparam int SIG_FE   = 3;
    localparam int SIG_HB   = 4;

    logic clk;
    logic rst;
    logic pll_locked_i;
    logic fetch_btn_n_i;
    logic clk_div_o;
    logic clk_div_rise_o;
    logic core_rst_n_o;
    logic fetch_enable_o;
    logic heartbeat_o;

    typedef struct {
        string name;
        int    sig;
        logic  val;
    } exp_t;

    typedef struct {
        logic locked;
        logic btn_n;
        logic div;
        logic rise;
        logic rstn;
        logic fe;
        logic hb;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    pulpino_clk_rst_gen #(
        .DIV_HALF       (2),
        .RST_HOLD_CYCLES(3),
        .DEBOUNCE_CYCLES(4),
        .HB_HALF        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked_i  (pll_locked_i),
        .fetch_btn_n_i (fetch_btn_n_i),
        .clk_div_o     (clk_div_o),
        .clk_div_rise_o(clk_div_rise_o),
        .core_rst_n_o  (core_rst_n_o),
        .fetch_enable_o(fetch_enable_o),
        .heartbeat_o   (heartbeat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic getOut(input int sig);
        case (sig)
            SIG_DIV:  return clk_div_o;
            SIG_RISE: return clk_div_rise_o;
            SIG_RSTN: return core_rst_n_o;
            SIG_FE:   return fetch_enable_o;
            SIG_HB:   return heartbeat_o;
            default:  return 1'bx;
        endcase
    endfunction

    task automatic applyStimulus(input logic locked, input logic btn_n);
        pll_locked_i  = locked;
        fetch_btn_n_i = btn_n;
    endtask

    task automatic expectOut(input string name, input int sig, input logic val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (getOut(e.sig) !== e.val) begin
                errors++;
                $display("[TB] FAIL %s (edge %0d): got %b, expected %b",
                         e.name, edge_n, getOut(e.sig), e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
        checkOutput();
    endtask

    task automatic runTo(input int n);
        while (edge_n < n) step();
    endtask

    task automatic expectAllZero(input string tag);
        expectOut({tag, "_div"},  SIG_DIV,  1'b0);
        expectOut({tag, "_rise"}, SIG_RISE, 1'b0);
        expectOut({tag, "_rstn"}, SIG_RSTN, 1'b0);
        expectOut({tag, "_fe"},   SIG_FE,   1'b0);
        expectOut({tag, "_hb"},   SIG_HB,   1'b0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Edges 1..16 after reset release, lock held high, button released.
        //             lk   bt   div  rise rstn fe   hb
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        expectAllZero("in_reset");
        checkOutput();

        releaseReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].locked, vecs[i].btn_n);
            expectOut($sformatf("vec%0d_div", i + 1),  SIG_DIV,  vecs[i].div);
            expectOut($sformatf("vec%0d_rise", i + 1), SIG_RISE, vecs[i].rise);
            expectOut($sformatf("vec%0d_rstn", i + 1), SIG_RSTN, vecs[i].rstn);
            expectOut($sformatf("vec%0d_fe", i + 1),   SIG_FE,   vecs[i].fe);
            expectOut($sformatf("vec%0d_hb", i + 1),   SIG_HB,   vecs[i].hb);
            step();
        end

        // Short 3-cycle button glitch must not enable fetch.
        applyStimulus(1'b1, 1'b0);
        runTo(19);
        applyStimulus(1'b1, 1'b1);
        runTo(19);
        expectOut("glitch_fe_20", SIG_FE, 1'b0);
        step();
        runTo(22);
        expectOut("hb_23", SIG_HB, 1'b0);
        step();
        expectOut("hb_24", SIG_HB, 1'b1);
        step();
        runTo(25);
        expectOut("glitch_fe_26", SIG_FE, 1'b0);
        expectOut("run_rstn_26", SIG_RSTN, 1'b1);
        step();

        // Real press after edge 26: accepted 2 sync + 4 debounce + 1 edges later.
        applyStimulus(1'b1, 1'b0);
        runTo(31);
        expectOut("press_fe_32", SIG_FE, 1'b0);
        step();
        expectOut("press_fe_33", SIG_FE, 1'b1);
        step();

        // One-cycle lock drop, then full hold sequence again.
        runTo(34);
        applyStimulus(1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0);
        expectOut("drop_rstn_36", SIG_RSTN, 1'b1);
        step();
        expectOut("drop_rstn_37", SIG_RSTN, 1'b0);
        expectOut("drop_fe_37", SIG_FE, 1'b1);
        step();
        expectOut("drop_fe_38", SIG_FE, 1'b0);
        step();
        runTo(45);
        expectOut("relock_rstn_46", SIG_RSTN, 1'b0);
        step();
        expectOut("relock_rstn_47", SIG_RSTN, 1'b1);
        expectOut("relock_fe_47", SIG_FE, 1'b0);
        step();
        expectOut("relock_fe_48", SIG_FE, 1'b1);
        step();

        // Button release is debounced the same way.
        applyStimulus(1'b1, 1'b1);
        runTo(53);
        expectOut("release_fe_54", SIG_FE, 1'b1);
        step();
        expectOut("release_fe_55", SIG_FE, 1'b0);
        step();

        applyStimulus(1'b1, 1'b0);
        runTo(61);
        expectOut("repress_fe_62", SIG_FE, 1'b1);
        step();
        runTo(63);
        expectOut("pre_rst_div_63", SIG_DIV, 1'b1);
        expectOut("pre_rst_hb_63", SIG_HB, 1'b1);
        checkOutput();

        // Asynchronous reset between clock edges, button still pressed.
        #2;
        rst = 1'b1;
        #1;
        expectAllZero("async_rst");
        checkOutput();
        repeat (2) @(negedge clk);
        releaseReset();
        runTo(1);
        expectOut("restart_div_2", SIG_DIV, 1'b1);
        step();
        runTo(9);
        expectOut("restart_rstn_10", SIG_RSTN, 1'b0);
        step();
        expectOut("restart_rstn_11", SIG_RSTN, 1'b1);
        expectOut("restart_fe_11", SIG_FE, 1'b0);
        step();
        expectOut("restart_fe_12", SIG_FE, 1'b1);
        step();

        // Lock absent at reset release, raised after edge 20.
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        releaseReset();
        runTo(19);
        expectOut("nolock_rstn_20", SIG_RSTN, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1);
        runTo(29);
        expectOut("lock_rstn_30", SIG_RSTN, 1'b0);
        step();
        expectOut("lock_rstn_31", SIG_RSTN, 1'b1);
        step();
        expectOut("lock_fe_32", SIG_FE, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
